// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch redirect,
// and the push side of the fetch queue feeding decode.
interface fetch_if #(
   parameter int XLEN = 32
);
   logic                imem_req_valid;
   logic [XLEN-1:0]     imem_req_addr;
   logic                imem_req_ready;
   logic                imem_resp_valid;
   logic [XLEN-1:0]     imem_resp_data;
   logic                redirect_valid;
   logic [XLEN-1:0]     redirect_pc;
   logic                fq_full;
   logic                fq_write_en;
   logic [2*XLEN-1:0]   fq_write_data;
   logic [31:0]         fetch_count;

   // The fetch unit drives requests and queue pushes; everything else comes in.
   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data,
      input  redirect_valid,
      input  redirect_pc,
      input  fq_full,
      output fq_write_en,
      output fq_write_data,
      output fetch_count
   );

   // Memory, branch unit and fetch queue as seen from the outside.
   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data,
      output redirect_valid,
      output redirect_pc,
      output fq_full,
      input  fq_write_en,
      input  fq_write_data,
      input  fetch_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, keeps at most one instruction-memory read
// outstanding, and pushes {pc, instr} into the fetch queue. A redirect always wins:
// the PC is reloaded at that edge and any request already in flight for the old PC
// is drained and discarded in S_FLUSH so it can never reach the queue.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic    clk,
   input  logic    reset,
   fetch_if.master io_fetch
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_PUSH  = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_holdPc;
   logic [XLEN-1:0]   r_holdInstr;
   logic [31:0]       r_fetchCount;

   logic              w_reqValid;
   logic              w_accept;
   logic              w_capture;
   logic              w_push;
   logic [XLEN-1:0]   w_redirectPc;
   logic [XLEN-1:0]   w_resetPc;

   // Instructions are word aligned, so the two low PC bits are always cleared.
   assign w_redirectPc = {io_fetch.redirect_pc[XLEN-1:2], 2'b00};
   assign w_resetPc    = {RESET_PC[XLEN-1:2], 2'b00};

   // Next-state and handshake decode; redirect is checked first in every state.
   always_comb begin
      w_nextState = r_state;
      w_reqValid  = 1'b0;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         S_REQ: begin
            w_reqValid = 1'b1;
            w_accept   = io_fetch.imem_req_ready;
            if (io_fetch.redirect_valid) begin
               w_nextState = w_accept ? S_FLUSH : S_REQ;
            end else if (w_accept) begin
               w_nextState = S_WAIT;
            end
         end
         S_WAIT: begin
            if (io_fetch.redirect_valid) begin
               w_nextState = io_fetch.imem_resp_valid ? S_REQ : S_FLUSH;
            end else if (io_fetch.imem_resp_valid) begin
               w_capture   = 1'b1;
               w_nextState = S_PUSH;
            end
         end
         S_PUSH: begin
            if (io_fetch.redirect_valid) begin
               w_nextState = S_REQ;
            end else if (!io_fetch.fq_full) begin
               w_push      = 1'b1;
               w_nextState = S_REQ;
            end
         end
         S_FLUSH: begin
            if (io_fetch.imem_resp_valid) begin
               w_nextState = S_REQ;
            end
         end
         default: begin
            w_nextState = S_REQ;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_nextState;
      end
   end

   // PC: redirect target first, otherwise step one word after each push.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= w_resetPc;
      end else if (io_fetch.redirect_valid) begin
         r_pc <= w_redirectPc;
      end else if (w_push) begin
         r_pc <= r_pc + XLEN'(4);
      end
   end

   // Hold registers keep the returned word and its PC stable while the queue is full.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_holdPc    <= '0;
         r_holdInstr <= '0;
      end else if (w_capture) begin
         r_holdPc    <= r_pc;
         r_holdInstr <= io_fetch.imem_resp_data;
      end
   end

   // Pushed-instruction counter; wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetchCount <= '0;
      end else if (w_push) begin
         r_fetchCount <= r_fetchCount + 32'd1;
      end
   end

   assign io_fetch.imem_req_valid = w_reqValid;
   assign io_fetch.imem_req_addr  = r_pc;
   assign io_fetch.fq_write_en    = w_push;
   assign io_fetch.fq_write_data  = {r_holdPc, r_holdInstr};
   assign io_fetch.fetch_count    = r_fetchCount;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural instruction memory answers each
// accepted request after a programmable latency; expected queue pushes are queued by
// the stimulus and popped by an independent monitor whenever fq_write_en is seen.
module tb_fetch_unit;

   logic clk;
   logic reset;

   fetch_if #(.XLEN(32)) fbus ();

   fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .io_fetch (fbus.master)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sbQueue[$];

   int          memLatency = 1;
   logic        memPending;
   logic [31:0] memAddr;
   int          memCount;

   // Free-running clock, rising edge active.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a recognisable tag in the upper half, the address below.
   function automatic logic [31:0] imemData(input logic [31:0] a);
      return 32'hDEAD_0000 | {16'h0000, a[15:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic ready, input logic full,
                                input logic redirV, input logic [31:0] redirPc);
      reset                 = rst;
      fbus.imem_req_ready   = ready;
      fbus.fq_full          = full;
      fbus.redirect_valid   = redirV;
      fbus.redirect_pc      = redirPc;
   endtask

   task automatic sbPush(input logic [63:0] exp);
      sbQueue.push_back(exp);
   endtask

   // Waits for the next push and parks the fetch unit by dropping ready afterwards.
   task automatic waitPush(input int maxCycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk);
         #2;
         if (fbus.fq_write_en) begin
            seen = 1'b1;
            fbus.imem_req_ready = 1'b0;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL push_timeout actual=no_push required=push within %0d cycles", maxCycles);
      end
   endtask

   // Instruction memory: respond memLatency cycles after each accepted request.
   initial begin
      fbus.imem_resp_valid = 1'b0;
      fbus.imem_resp_data  = '0;
      memPending           = 1'b0;
      memAddr              = '0;
      memCount             = 0;
      forever begin
         @(negedge clk);
         fbus.imem_resp_valid = 1'b0;
         if (memPending) begin
            if (memCount == 0) begin
               fbus.imem_resp_valid = 1'b1;
               fbus.imem_resp_data  = imemData(memAddr);
               memPending           = 1'b0;
            end else begin
               memCount--;
            end
         end
         #2;
         if (!reset && fbus.imem_req_valid && fbus.imem_req_ready) begin
            memPending = 1'b1;
            memAddr    = fbus.imem_req_addr;
            memCount   = memLatency - 1;
         end
      end
   end

   // Monitor: every observed push must match the oldest expected entry.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            if (fbus.fq_full) begin
               checkOutput("wen_while_full", 64'(fbus.fq_write_en), 64'd0);
            end
            if (fbus.fq_write_en) begin
               if (sbQueue.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_push actual=%h required=no_push", fbus.fq_write_data);
               end else begin
                  exp = sbQueue.pop_front();
                  checkOutput("push_data", fbus.fq_write_data, exp);
               end
            end
         end
      end
   end

   // Hard stop in case the design locks up somewhere no bounded wait covers.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios.
   initial begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      repeat (3) @(negedge clk);

      // Reset state, then three back-to-back fetches with single-cycle memory.
      sbPush(64'h0000_0000_DEAD_0000);
      sbPush(64'h0000_0004_DEAD_0004);
      sbPush(64'h0000_0008_DEAD_0008);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      #2;
      checkOutput("rst_req_valid", 64'(fbus.imem_req_valid), 64'd1);
      checkOutput("rst_req_addr",  64'(fbus.imem_req_addr),  64'h0);
      checkOutput("rst_wen",       64'(fbus.fq_write_en),    64'd0);
      checkOutput("rst_wdata",     fbus.fq_write_data,       64'h0);
      checkOutput("rst_count",     64'(fbus.fetch_count),    64'd0);
      for (int k = 1; k < 9; k++) begin
         @(negedge clk);
         #2;
         checkOutput("t1_wen_cadence", 64'(fbus.fq_write_en), 64'((k % 3) == 2));
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      checkOutput("t1_count", 64'(fbus.fetch_count),  64'd3);
      checkOutput("t1_addr",  64'(fbus.imem_req_addr), 64'h0000_000C);

      // Queue full for five cycles while holding a fetched word.
      sbPush(64'h0000_000C_DEAD_000C);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #2;
         checkOutput("t2_wen_stall",  64'(fbus.fq_write_en),   64'd0);
         checkOutput("t2_data_hold",  fbus.fq_write_data,      64'h0000_000C_DEAD_000C);
         checkOutput("t2_pc_hold",    64'(fbus.imem_req_addr), 64'h0000_000C);
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      checkOutput("t2_release_wen", 64'(fbus.fq_write_en), 64'd1);
      @(negedge clk);
      #2;
      checkOutput("t2_next_addr", 64'(fbus.imem_req_addr), 64'h0000_0010);
      checkOutput("t2_count",     64'(fbus.fetch_count),   64'd4);

      // Redirect while waiting; the late response for 0x10 must be thrown away.
      memLatency = 2;
      sbPush(64'h0000_0100_DEAD_0100);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
      #2;
      checkOutput("t3_wait_req", 64'(fbus.imem_req_valid), 64'd0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      checkOutput("t3_flush_req", 64'(fbus.imem_req_valid), 64'd0);
      @(negedge clk);
      #2;
      checkOutput("t3_req_valid", 64'(fbus.imem_req_valid), 64'd1);
      checkOutput("t3_req_addr",  64'(fbus.imem_req_addr),  64'h0000_0100);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      waitPush(20);

      // Redirect to an unaligned target during the push cycle.
      memLatency = 1;
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0203);
      #2;
      checkOutput("t4_wen_killed", 64'(fbus.fq_write_en), 64'd0);
      checkOutput("t4_held_data",  fbus.fq_write_data,    64'h0000_0104_DEAD_0104);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      checkOutput("t4_req_valid", 64'(fbus.imem_req_valid), 64'd1);
      checkOutput("t4_req_addr",  64'(fbus.imem_req_addr),  64'h0000_0200);
      checkOutput("t4_count",     64'(fbus.fetch_count),    64'd5);
      sbPush(64'h0000_0200_DEAD_0200);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      waitPush(20);

      // Memory not ready: request held; then reset lands while a read is in flight.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #2;
         checkOutput("t5_hold_valid", 64'(fbus.imem_req_valid), 64'd1);
         checkOutput("t5_hold_addr",  64'(fbus.imem_req_addr),  64'h0000_0204);
      end
      memLatency = 3;
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      #2;
      checkOutput("t5_single_outstanding", 64'(fbus.imem_req_valid), 64'd0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      #2;
      checkOutput("t5_rst_valid", 64'(fbus.imem_req_valid), 64'd1);
      checkOutput("t5_rst_addr",  64'(fbus.imem_req_addr),  64'h0000_0000);
      checkOutput("t5_rst_count", 64'(fbus.fetch_count),    64'd0);
      @(negedge clk);
      #2;
      checkOutput("t5_stray_valid", 64'(fbus.imem_req_valid), 64'd1);
      checkOutput("t5_stray_addr",  64'(fbus.imem_req_addr),  64'h0000_0000);
      memLatency = 1;
      sbPush(64'h0000_0000_DEAD_0000);
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      waitPush(20);

      // Counter wrap from all ones.
      @(negedge clk);
      force dut.r_fetchCount = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_fetchCount;
      sbPush(64'h0000_0004_DEAD_0004);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      waitPush(20);
      @(negedge clk);
      #2;
      checkOutput("t6_count_wrap", 64'(fbus.fetch_count), 64'd0);

      @(negedge clk);
      #2;
      checkOutput("sb_drained", 64'(sbQueue.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
